// File: rtl/pipe_rate_change_ctrl.sv
// PIPE receive-side link-speed change sequencer: holds the Rx path quiet while
// the Rate/PhyStatus handshake runs, then switches the GEN width select.
module pipe_rate_change_ctrl #(
    parameter int EIDLE_TIMEOUT = 1024,
    parameter int PHY_TIMEOUT   = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_gen,
    output logic       req_ready,
    input  logic       PhyStatus,
    input  logic       RxElectricalIdle,
    output logic [2:0] Rate,
    output logic [2:0] GEN,
    output logic       rx_hold,
    output logic       busy,
    output logic       change_done,
    output logic       change_err
);

    // state       | meaning
    // IDLE        | ready for an LTSSM request, Rx path live
    // WAIT_EIDLE  | Rx held, waiting for receiver electrical idle
    // WAIT_PHY    | new Rate driven, waiting for PhyStatus
    // SETTLE      | GEN switched, Rx still held for SETTLE_CYCLES
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_EIDLE = 2'd1,
        WAIT_PHY   = 2'd2,
        SETTLE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] EIDLE_TC   = CNT_W'(EIDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PHY_TC     = CNT_W'(PHY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       target_q, target_d;
    logic [2:0]       gen_q, gen_d;
    logic [2:0]       rate_q, rate_d;
    logic             hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             gen_legal;
    logic [CNT_W-1:0] cnt_inc;

    assign gen_legal = (req_gen >= 3'd1) && (req_gen <= 3'd5);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        gen_d    = gen_q;
        rate_d   = rate_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!gen_legal) begin
                        err_d = 1'b1;
                    end else if (req_gen == gen_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = req_gen;
                        state_d  = WAIT_EIDLE;
                        cnt_d    = '0;
                        hold_d   = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            WAIT_EIDLE: begin
                cnt_d = cnt_inc;
                // the event is checked first so it wins over a same-edge timeout
                if (RxElectricalIdle) begin
                    rate_d  = target_q - 3'd1;
                    state_d = WAIT_PHY;
                    cnt_d   = '0;
                end else if (cnt_q == EIDLE_TC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rate_d  = gen_q - 3'd1;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            WAIT_PHY: begin
                cnt_d = cnt_inc;
                if (PhyStatus) begin
                    gen_d   = target_q;
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end else if (cnt_q == PHY_TC) begin
                    // abort: put the PHY back on the rate matching the unchanged GEN
                    state_d = IDLE;
                    cnt_d   = '0;
                    rate_d  = gen_q - 3'd1;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 3'd1;
            gen_q    <= 3'd1;
            rate_q   <= 3'd0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            gen_q    <= gen_d;
            rate_q   <= rate_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign Rate        = rate_q;
    assign GEN         = gen_q;
    assign rx_hold     = hold_q;
    assign busy        = busy_q;
    assign change_done = done_q;
    assign change_err  = err_q;

endmodule

// File: doc/pipe_rate_change_ctrl.md
Name: pipe_rate_change_ctrl

Overview:
Sequences a PIPE receive-side link-speed change between the LTSSM and the PHY.
- Accepts a target generation from the LTSSM and holds the Rx data path quiet during the change.
- Runs the Rate / PhyStatus handshake with the PHY, then switches the GEN select that the PIPE Rx data path uses for width selection.
- Sits between the LTSSM (Recovery.Speed) and the PIPE Rx data block; it is the only driver of GEN and Rate.

Parameters:
EIDLE_TIMEOUT, 1024, max cycles to wait for RxElectricalIdle before aborting (>=1)
PHY_TIMEOUT, 4096, max cycles to wait for PhyStatus after Rate change (>=1)
SETTLE_CYCLES, 16, cycles rx_hold stays asserted after GEN update (>=0)
CNT_W, 16, timeout/settle counter width; must hold max(EIDLE_TIMEOUT, PHY_TIMEOUT, SETTLE_CYCLES)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  LTSSM speed-change request
- req_gen  input  3  target generation, legal 1..5
- req_ready  output  1  high only in IDLE
- PhyStatus  input  1  PHY rate-change completion pulse
- RxElectricalIdle  input  1  PHY receiver electrical idle
- Rate  output  3  PHY rate, encoding = gen-1
- GEN  output  3  generation select to the PIPE Rx data path
- rx_hold  output  1  high = data path must treat RxValid as 0
- busy  output  1  high in any state other than IDLE
- change_done  output  1  one-cycle pulse, change completed
- change_err  output  1  one-cycle pulse, request rejected or aborted

Behaviour:
- Reset (async, low), all registered: state=IDLE, GEN=1, Rate=0, rx_hold=0, busy=0, change_done=0, change_err=0, counter=0, saved target=1. Reset mid-change returns to these values immediately with no pulses. Rate therefore returns to Gen1 even if the PHY was mid-switch.
- States: IDLE, WAIT_EIDLE, WAIT_PHY, SETTLE. Encoding is an implementer choice.
- Counter: cleared on every state entry; increments by 1 per cycle in WAIT_EIDLE/WAIT_PHY; saturates and never wraps.
- IDLE:
  - req_ready=1. Acceptance happens at the clock edge where req_valid=1 and req_ready=1.
  - req_gen not in 1..5: change_err=1 next cycle, stay IDLE.
  - req_gen==GEN: change_done=1 next cycle, stay IDLE, no PHY handshake.
  - Otherwise: latch target, go to WAIT_EIDLE; rx_hold=1 and busy=1 from the next cycle.
- WAIT_EIDLE:
  - Edge with RxElectricalIdle=1: Rate<=target-1, go to WAIT_PHY.
  - Else if counter==EIDLE_TIMEOUT-1: abort.
- WAIT_PHY:
  - PhyStatus is ignored in every other state, including the cycle the Rate write occurs.
  - Edge with PhyStatus=1: GEN<=target, go to SETTLE with counter loaded to SETTLE_CYCLES.
  - Else if counter==PHY_TIMEOUT-1: abort.
- SETTLE:
  - Counter decrements each cycle.
  - Edge with counter==0: go to IDLE; rx_hold=0, busy=0, change_done=1 for one cycle.
  - SETTLE_CYCLES=0 gives a single SETTLE cycle.
- Abort (timeout): go to IDLE; Rate<=GEN-1 (restore old rate); GEN unchanged; rx_hold=0; busy=0; change_err=1 for one cycle.
- Simultaneous event and timeout on the same edge: the event wins.
- Requests while busy: not accepted (req_ready=0). The LTSSM keeps req_valid high until accepted. A request can be accepted on the first cycle back in IDLE, which is the same cycle change_done/change_err is high.
- change_done and change_err are mutually exclusive.
- Latency, edge-to-edge, for a clean change when eidle and PhyStatus are immediate:
  - accept edge -> rx_hold=1: 1 cycle
  - Rate update: 2 cycles after accept
  - GEN update: 3 cycles after accept
  - change_done: 4+SETTLE_CYCLES cycles after accept

Test Plan:
- GEN=1; req_gen=3 with RxElectricalIdle=1 and PhyStatus pulsed 5 cycles after Rate changes, SETTLE_CYCLES=16 -> Rate=2, then GEN=3 on the PhyStatus edge; rx_hold high from accept+1 through SETTLE; change_done single pulse 17 cycles after GEN update; req_ready low throughout.
- GEN=2; req_gen=2 -> change_done next cycle; Rate and rx_hold untouched; busy never high.
- req_gen=0, 6 and 7 -> change_err one cycle each; GEN, Rate, state unchanged.
- req_gen=4 with PhyStatus never asserted, PHY_TIMEOUT=8 -> Rate=3 for exactly 8 WAIT_PHY cycles, then Rate restored to old GEN-1, change_err pulse, GEN unchanged. Repeat with PhyStatus on the last timeout cycle -> success path taken.
- RxElectricalIdle held 0, EIDLE_TIMEOUT=4 -> change_err after 4 WAIT_EIDLE cycles; Rate never changes. Also: PhyStatus pulsed during WAIT_EIDLE -> ignored.
- Assert reset during SETTLE after Gen1->Gen5 -> GEN=1, Rate=0, rx_hold=0, no pulses. After release, a new request of 5 is accepted on the first IDLE cycle.
